tl_ad_channel_buffer: RTL

- Parametrised TileLink-UL buffer stage inserted between a client-side A/D port pair and a manager-side A/D port pair. Successor to the fixed single-entry A-source/D-sink buffer pair.
- Adds independent A and D queue depths, generic field widths, occupancy reporting and an idle indication for clock gating.
- Placed on crossbar-to-peripheral edges to break long timing paths.

---
 rtl/tl_ad_channel_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tl_ad_channel_buffer.sv
// TileLink-UL A/D buffer stage: independent circular FIFOs on the A (client->manager) and D channels.
// Optional macro TL_AD_BUFFER_FLOW_EN adds a zero-latency bypass when a channel queue is empty.

module tl_ad_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits,
  output logic [4:0]       count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [4:0] FULL = 5'(DEPTH);

  // Sized to a power of two so pointers index it at their natural width.
  logic [WIDTH-1:0] mem [1<<PW];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [4:0]       count_reg;
  logic             enq;
  logic             deq;
  logic             empty;

  assign empty    = (count_reg == 5'd0);
  assign in_ready = (count_reg != FULL);
  assign count    = count_reg;

`ifdef TL_AD_BUFFER_FLOW_EN
  logic pass;
  // An empty queue forwards the input directly; it is stored only if the sink stalls.
  assign pass      = empty && in_valid && out_ready;
  assign out_valid = !empty || in_valid;
  assign out_bits  = empty ? in_bits : mem[rd_ptr_reg];
  assign enq       = in_valid && in_ready && !pass;
  assign deq       = !empty && out_ready;
`else
  assign out_valid = !empty;
  assign out_bits  = mem[rd_ptr_reg];
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
`endif

  always_ff @(posedge clock) begin
    if (reset && enq) begin
      mem[wr_ptr_reg] <= in_bits;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 5'd0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (deq) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + 5'd1;
        2'b01:   count_reg <= count_reg - 5'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifndef SYNTHESIS
  depth_legal: assert property (@(posedge clock) (DEPTH >= 1) && (DEPTH <= 16));
  bits_hold: assert property (@(posedge clock) disable iff (!reset)
    (out_valid && !out_ready) |=> $stable(out_bits));
`endif
endmodule

module tl_ad_channel_buffer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SOURCE_W = 9,
  parameter int SIZE_W   = 2,
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  localparam int A_W = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W + 1,
  localparam int D_W = 3 + 2 + SIZE_W + SOURCE_W + 1 + 1 + DATA_W + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_a_valid,
  output logic           in_a_ready,
  input  logic [A_W-1:0] in_a_bits,
  output logic           out_a_valid,
  input  logic           out_a_ready,
  output logic [A_W-1:0] out_a_bits,
  input  logic           in_d_valid,
  output logic           in_d_ready,
  input  logic [D_W-1:0] in_d_bits,
  output logic           out_d_valid,
  input  logic           out_d_ready,
  output logic [D_W-1:0] out_d_bits,
  output logic [4:0]     a_count,
  output logic [4:0]     d_count,
  output logic           idle
);
  tl_ad_fifo #(.WIDTH(A_W), .DEPTH(A_DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_a_valid),
    .in_ready  (in_a_ready),
    .in_bits   (in_a_bits),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready),
    .out_bits  (out_a_bits),
    .count     (a_count)
  );

  tl_ad_fifo #(.WIDTH(D_W), .DEPTH(D_DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_d_valid),
    .in_ready  (in_d_ready),
    .in_bits   (in_d_bits),
    .out_valid (out_d_valid),
    .out_ready (out_d_ready),
    .out_bits  (out_d_bits),
    .count     (d_count)
  );

  // Clock-gating hint: derived only from the registered occupancies.
  assign idle = (a_count == 5'd0) && (d_count == 5'd0);

`ifndef SYNTHESIS
  data_w_legal: assert property (@(posedge clock) (DATA_W == 32) || (DATA_W == 64));
`endif
endmodule
